// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA sequencer and external-bus arbiter between the CPU core and the OAM DMA engine
module oam_dma_ctrl #(
  parameter int          XFER_LEN = 160,
  parameter logic [15:0] DMA_REG  = 16'hff46
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        t1,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [15:0] bus_adr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active,
  output logic [7:0]  dma_reg
);
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;
  state_t state, state_nx;
  logic [7:0] idx, src_hi;
  logic [1:0] tc;
  logic restart, seen, reg_wr, t4, last, lo;
  assign reg_wr = cpu_wr && cpu_adr == DMA_REG;
  // tc counts T-cycles since the last t1, so tc==3 marks T4 once a t1 has been seen
  assign t4 = tc == 2'd3;
  assign last = idx == 8'(XFER_LEN - 1);
  assign lo = cpu_adr < 16'hff00;
  // state register
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) state <= IDLE;
    else state <= state_nx;
  // next state: a register write always wins, START leaves at the T4 after its first t1
  always_comb begin
    state_nx = state;
    if (reg_wr) state_nx = START;
    else if (state == START && seen && t4) state_nx = XFER;
    else if (state == XFER && t4 && last) state_nx = IDLE;
  end
  // bus arbitration and fencing, combinational from state/idx/CPU inputs
  always_comb begin
    dma_active = state == XFER || (state == START && restart);
    bus_adr = dma_active ? {src_hi, idx} : cpu_adr;
    bus_rd = dma_active ? state == XFER : cpu_rd && lo;
    bus_wr = !dma_active && cpu_wr && lo;
    bus_dout = cpu_dout;
    cpu_din = (dma_active && lo) ? 8'hff : bus_din;
  end
  // phase tracking, register capture, byte index and OAM write strobe
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      tc <= 2'd0;
      idx <= 8'd0;
      src_hi <= 8'd0;
      restart <= 1'b0;
      seen <= 1'b0;
      dma_reg <= 8'd0;
      oam_we <= 1'b0;
      oam_adr <= 8'd0;
      oam_wdata <= 8'd0;
    end else begin
      tc <= t1 ? 2'd1 : tc + 2'd1;
      oam_we <= state == XFER && tc == 2'd2;
      if (state == XFER && tc == 2'd2) begin
        oam_adr <= idx;
        oam_wdata <= bus_din;
      end
      if (reg_wr) begin
        dma_reg <= cpu_dout;
        src_hi <= (cpu_dout >= 8'hfe) ? (cpu_dout & 8'hdf) : cpu_dout;
        idx <= 8'd0;
        seen <= 1'b0;
        restart <= state == XFER || (state == START && restart);
      end else begin
        if (state == START && t1) seen <= 1'b1;
        if (state == XFER && t4) begin
          idx <= idx + 8'd1;
          if (last) restart <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: checks oam_dma_ctrl against a per-cycle schedule of expected DMA activity
module tb_oam_dma_ctrl;
  localparam int MAXC = 8192;
  logic clk = 1'b0, nreset = 1'b0, t1;
  logic [15:0] cpu_adr = 16'h0000;
  logic cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0] cpu_dout = 8'h00, cpu_din, bus_dout, bus_din, oam_adr, oam_wdata, dma_reg;
  logic [15:0] bus_adr;
  logic bus_rd, bus_wr, oam_we, dma_active;
  int cyc = 0, tests = 0, fails = 0, we_cnt = 0, act_cnt = 0;
  logic chk_en = 1'b0;
  logic exp_act [MAXC], exp_rd [MAXC], exp_we [MAXC];
  logic [15:0] exp_adr [MAXC];
  logic [7:0] exp_oa [MAXC], exp_od [MAXC];

  oam_dma_ctrl dut (
    .clk(clk), .nreset(nreset), .t1(t1), .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .bus_adr(bus_adr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_dout(bus_dout), .bus_din(bus_din), .oam_adr(oam_adr), .oam_wdata(oam_wdata),
    .oam_we(oam_we), .dma_active(dma_active), .dma_reg(dma_reg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign t1 = (cyc % 4) == 0;
  assign bus_din = bus_adr[7:0] ^ 8'h5a;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int n);
    while (cyc < n) step();
    @(negedge clk);
  endtask

  // a write at cycle w: first t1 after w, one more M-cycle, then XFER_LEN M-cycles of reads
  task automatic model_start(input int w, input logic [7:0] d);
    logic [7:0] src = (d >= 8'hfe) ? (d & 8'hdf) : d;
    logic rs = exp_act[w];
    int xs = (w / 4 + 1) * 4 + 4;
    for (int n = w + 1; n < MAXC; n++) begin
      exp_act[n] = (n < xs) ? rs : 1'b0;
      exp_rd[n] = 1'b0;
      if (n > w + 1) exp_we[n] = 1'b0;
    end
    for (int n = xs; n < xs + 640 && n < MAXC; n++) begin
      logic [7:0] k = 8'((n - xs) / 4);
      exp_act[n] = 1'b1;
      exp_rd[n] = 1'b1;
      exp_adr[n] = {src, k};
      if ((n - xs) % 4 == 3) begin
        exp_we[n] = 1'b1;
        exp_oa[n] = k;
        exp_od[n] = k ^ 8'h5a;
      end
    end
  endtask

  task automatic model_reset(input int r);
    for (int n = r; n < MAXC; n++) begin
      exp_act[n] = 1'b0;
      exp_rd[n] = 1'b0;
      exp_we[n] = 1'b0;
    end
  endtask

  task automatic wr(input logic [15:0] adr, input logic [7:0] d, input int tgt, output int w);
    while (cyc < tgt) step();
    cpu_adr = adr;
    cpu_dout = d;
    cpu_wr = 1'b1;
    w = cyc;
    if (adr == 16'hff46) model_start(w, d);
    step();
    cpu_wr = 1'b0;
    cpu_adr = 16'h0000;
  endtask

  function automatic int next_t4(input int c);
    return (c / 4 + 1) * 4 + 3;
  endfunction

  always @(negedge clk) if (chk_en && cyc < MAXC) begin
    chk("dma_active", 16'(dma_active), 16'(exp_act[cyc]));
    chk("oam_we", 16'(oam_we), 16'(exp_we[cyc]));
    if (exp_we[cyc]) begin
      chk("oam_adr", 16'(oam_adr), 16'(exp_oa[cyc]));
      chk("oam_wdata", 16'(oam_wdata), 16'(exp_od[cyc]));
    end
    if (exp_act[cyc]) begin
      chk("dma_bus_rd", 16'(bus_rd), 16'(exp_rd[cyc]));
      if (exp_rd[cyc]) chk("dma_bus_adr", bus_adr, exp_adr[cyc]);
      chk("fenced_bus_wr", 16'(bus_wr), 16'h0);
      if (cpu_adr < 16'hff00) chk("fenced_cpu_din", 16'(cpu_din), 16'h00ff);
    end else begin
      chk("pass_bus_adr", bus_adr, cpu_adr);
      chk("pass_bus_rd", 16'(bus_rd), 16'(cpu_rd && cpu_adr < 16'hff00));
      chk("pass_bus_wr", 16'(bus_wr), 16'(cpu_wr && cpu_adr < 16'hff00));
      chk("pass_bus_dout", 16'(bus_dout), 16'(cpu_dout));
      chk("pass_cpu_din", 16'(cpu_din), 16'(bus_din));
    end
    if (oam_we) we_cnt++;
    if (dma_active) act_cnt++;
  end

  initial begin
    int w, xs, w0;
    for (int n = 0; n < MAXC; n++) begin
      exp_act[n] = 1'b0; exp_rd[n] = 1'b0; exp_we[n] = 1'b0;
      exp_adr[n] = 16'h0; exp_oa[n] = 8'h0; exp_od[n] = 8'h0;
    end
    at_neg(2);
    chk("rst_dma_active", 16'(dma_active), 16'h0);
    chk("rst_oam_we", 16'(oam_we), 16'h0);
    chk("rst_dma_reg", 16'(dma_reg), 16'h0);
    step();
    nreset = 1'b1;
    chk_en = 1'b1;
    // idle pass-through read and high-page read
    step();
    cpu_adr = 16'h0150;
    cpu_rd = 1'b1;
    @(negedge clk);
    chk("t6_bus_adr", bus_adr, 16'h0150);
    chk("t6_bus_rd", 16'(bus_rd), 16'h1);
    chk("t6_cpu_din", 16'(cpu_din), 16'h000a);
    step();
    cpu_adr = 16'hff80;
    @(negedge clk);
    chk("t6_hi_bus_rd", 16'(bus_rd), 16'h0);
    step();
    cpu_rd = 1'b0;
    cpu_adr = 16'h0000;
    // fresh transfer from $C1 with fenced CPU accesses in the middle
    we_cnt = 0;
    act_cnt = 0;
    wr(16'hff46, 8'hc1, next_t4(cyc), w);
    xs = w + 5;
    at_neg(xs - 1);
    chk("t1_not_yet_active", 16'(dma_active), 16'h0);
    at_neg(xs);
    chk("t1_first_adr", bus_adr, 16'hc100);
    at_neg(xs + 100);
    step();
    cpu_adr = 16'hc000;
    cpu_rd = 1'b1;
    @(negedge clk);
    chk("t2_fenced_rd", 16'(cpu_din), 16'h00ff);
    step();
    cpu_rd = 1'b0;
    cpu_adr = 16'hd000;
    cpu_dout = 8'h77;
    cpu_wr = 1'b1;
    @(negedge clk);
    chk("t2_fenced_wr", 16'(bus_wr), 16'h0);
    step();
    cpu_wr = 1'b0;
    cpu_adr = 16'h0000;
    at_neg(xs + 639);
    chk("t1_last_adr", bus_adr, 16'hc19f);
    at_neg(xs + 660);
    chk("t1_we_count", 16'(we_cnt), 16'd160);
    chk("t1_active_clks", 16'(act_cnt), 16'd640);
    chk("t1_dma_reg", 16'(dma_reg), 16'h00c1);
    // $FF maps to source page $DF
    wr(16'hff46, 8'hff, next_t4(cyc), w);
    xs = w + 5;
    at_neg(xs + 20);
    chk("t3_adr", bus_adr, 16'hdf05);
    chk("t3_dma_reg", 16'(dma_reg), 16'h00ff);
    at_neg(xs + 660);
    // restart at idx 50 from $80
    we_cnt = 0;
    act_cnt = 0;
    wr(16'hff46, 8'hc2, next_t4(cyc), w0);
    xs = w0 + 5;
    wr(16'hff46, 8'h80, xs + 203, w);
    at_neg(w + 2);
    chk("t4_fenced", 16'(dma_active), 16'h1);
    chk("t4_no_rd", 16'(bus_rd), 16'h0);
    at_neg(w + 5);
    chk("t4_new_adr", bus_adr, 16'h8000);
    at_neg(w + 670);
    chk("t4_we_count", 16'(we_cnt), 16'd211);
    chk("t4_active_clks", 16'(act_cnt), 16'd848);
    // write coincident with the final byte of a transfer
    we_cnt = 0;
    wr(16'hff46, 8'hc3, next_t4(cyc), w0);
    xs = w0 + 5;
    wr(16'hff46, 8'hc4, xs + 639, w);
    at_neg(w + 1);
    chk("t4b_restart", 16'(dma_active), 16'h1);
    at_neg(w + 670);
    chk("t4b_we_count", 16'(we_cnt), 16'd320);
    // reset at idx 10
    we_cnt = 0;
    wr(16'hff46, 8'h90, next_t4(cyc), w);
    xs = w + 5;
    while (cyc < xs + 41) step();
    nreset = 1'b0;
    model_reset(cyc);
    @(negedge clk);
    chk("t5_active", 16'(dma_active), 16'h0);
    chk("t5_oam_we", 16'(oam_we), 16'h0);
    chk("t5_oam_adr", 16'(oam_adr), 16'h0);
    chk("t5_oam_wdata", 16'(oam_wdata), 16'h0);
    chk("t5_dma_reg", 16'(dma_reg), 16'h0);
    step();
    step();
    nreset = 1'b1;
    at_neg(cyc + 700);
    chk("t5_we_count", 16'(we_cnt), 16'd10);
    we_cnt = 0;
    wr(16'hff46, 8'ha0, next_t4(cyc), w);
    xs = w + 5;
    at_neg(xs);
    chk("t5_clean_adr", bus_adr, 16'ha000);
    at_neg(xs + 660);
    chk("t5_clean_we", 16'(we_cnt), 16'd160);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
